dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 = CPU MEM stage, port 1 = DMA/debug loader.

---
 rtl/dmem_port_arbiter_pkg.sv | 22 ++
 rtl/dmem_starve_ctr.sv | 55 +++++
 rtl/dmem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Contents:
//   PORT_CPU / PORT_DMA      index of each requester in the grant vector
//   DMEM_ADDR_BITS           word-address width of the data memory (512 words)
//   DEFAULT_STARVE_LIMIT     denied cycles of the DMA port before it is forced a grant
//   STARVE_CTR_BITS          width of the starvation counter
//   addr_in_range()          word-aligned and inside the memory
package dmem_port_arbiter_pkg;

    localparam int PORT_CPU             = 0;
    localparam int PORT_DMA             = 1;
    localparam int DMEM_ADDR_BITS       = 9;
    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int STARVE_CTR_BITS      = 4;

    // Byte address must be word aligned and must not touch any bit above
    // the word index, otherwise the access is rejected.
    function automatic logic addr_in_range(input logic [31:0] addr, input int addr_bits);
        return ((addr >> (addr_bits + 2)) == 32'd0) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Starvation protection for the DMA port of the data-memory arbiter.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   p1_req_i   DMA port request
//   p1_gnt_i   DMA port grant this cycle
//   force_o    DMA port must win the next cycle it requests
module dmem_starve_ctr
    import dmem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic p1_req_i,
    input  logic p1_gnt_i,
    output logic force_o
);

    localparam logic [STARVE_CTR_BITS-1:0] LIMIT = STARVE_CTR_BITS'(STARVE_LIMIT);

    logic [STARVE_CTR_BITS-1:0] cnt_q, cnt_d;
    logic                       force_q, force_d;

    // Count denied cycles while the DMA port waits, saturating at the limit.
    // The force flag rises on the edge the count reaches the limit and only
    // drops once the DMA port has actually been served.
    always_comb begin
        cnt_d   = cnt_q;
        force_d = force_q;
        if (p1_gnt_i || !p1_req_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (p1_gnt_i) begin
            force_d = 1'b0;
        end else if (cnt_d == LIMIT) begin
            force_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q   <= '0;
            force_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            force_q <= force_d;
        end
    end

    assign force_o = force_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 is the CPU MEM stage (fixed priority), port 1 is the DMA/debug
// loader (protected from starvation). One access is issued per cycle; read
// data is registered and returned one cycle after the grant.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   p0_req/we/addr/wdata           CPU request
//   p0_gnt, p0_stall, p0_rvalid    CPU grant, pipeline stall, read valid
//   p1_req/we/addr/wdata           DMA request
//   p1_gnt, p1_rvalid              DMA grant, read valid
//   rdata                          registered read data shared by both ports
//   addr_err                       pulse after a granted out-of-range access
//   mem_addr/wdata/read/write      to the memory
//   mem_rdata                      combinational read data from the memory
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = DMEM_ADDR_BITS,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_stall,
    output logic        p0_rvalid,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  gnt;
    logic        force_dma;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;
    logic        any_gnt;

    logic        p0_rvalid_q, p0_rvalid_d;
    logic        p1_rvalid_q, p1_rvalid_d;
    logic        addr_err_q,  addr_err_d;
    logic [31:0] rdata_q,     rdata_d;

    dmem_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .p1_req_i  (p1_req),
        .p1_gnt_i  (gnt[PORT_DMA]),
        .force_o   (force_dma)
    );

    // Single winner per cycle. Grants are held off during reset so that no
    // memory strobe can leak out while reset_n is low.
    always_comb begin
        gnt = 2'b00;
        if (reset_n) begin
            if (force_dma && p1_req) begin
                gnt[PORT_DMA] = 1'b1;
            end else if (p0_req) begin
                gnt[PORT_CPU] = 1'b1;
            end else if (p1_req) begin
                gnt[PORT_DMA] = 1'b1;
            end
        end
    end

    // The DMA port only steers the memory bus when it holds the grant;
    // otherwise (including idle) the CPU port drives address and data.
    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (gnt[PORT_DMA]) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    assign any_gnt   = |gnt;
    assign in_range  = addr_in_range(sel_addr, ADDR_BITS);
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;
    assign mem_write = any_gnt &  sel_we & in_range;
    assign mem_read  = any_gnt & ~sel_we & in_range;

    assign p0_gnt   = gnt[PORT_CPU];
    assign p1_gnt   = gnt[PORT_DMA];
    assign p0_stall = p0_req & ~gnt[PORT_CPU];

    // A rejected read still completes with zero data so the requester is
    // never left waiting; rdata otherwise holds its last read value.
    always_comb begin
        p0_rvalid_d = gnt[PORT_CPU] & ~sel_we;
        p1_rvalid_d = gnt[PORT_DMA] & ~sel_we;
        addr_err_d  = any_gnt & ~in_range;
        rdata_d     = rdata_q;
        if (any_gnt && !sel_we) begin
            rdata_d = in_range ? mem_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            addr_err_q  <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            addr_err_q  <= addr_err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign addr_err  = addr_err_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a table of single-cycle
// accesses plus hand-written reset and starvation sequences, against a
// small behavioural data memory.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        p0_req, p0_we;
    logic [31:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_stall, p0_rvalid;
    logic        p1_req, p1_we;
    logic [31:0] p1_addr, p1_wdata;
    logic        p1_gnt, p1_rvalid;
    logic [31:0] rdata;
    logic        addr_err;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_stall  (p0_stall),
        .p0_rvalid (p0_rvalid),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .rdata     (rdata),
        .addr_err  (addr_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: word i starts as 0xA5000000 + i, combinational read,
    // write on the rising edge.
    logic [31:0] memModel [512];
    assign mem_rdata = memModel[mem_addr[10:2]];

    initial begin
        for (int i = 0; i < 512; i++) memModel[i] = 32'hA500_0000 + 32'(i);
        forever begin
            @(posedge clk);
            if (mem_write) memModel[mem_addr[10:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        p0Req, p0We;
        logic [31:0] p0Addr, p0Wdata;
        logic        p1Req, p1We;
        logic [31:0] p1Addr, p1Wdata;
        logic        expP0Gnt, expP1Gnt, expStall, expRead, expWrite;
        logic [31:0] expAddr, expWdata;
        logic        expRv0, expRv1, expErr, chkRdata;
        logic [31:0] expRdata;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        p0_req   = v.p0Req;
        p0_we    = v.p0We;
        p0_addr  = v.p0Addr;
        p0_wdata = v.p0Wdata;
        p1_req   = v.p1Req;
        p1_we    = v.p1We;
        p1_addr  = v.p1Addr;
        p1_wdata = v.p1Wdata;
    endtask

    task automatic checkOutput(input int idx, input vec_t v, input bit registered);
        if (!registered) begin
            checkBit ($sformatf("v%0d p0_gnt", idx),    p0_gnt,    v.expP0Gnt);
            checkBit ($sformatf("v%0d p1_gnt", idx),    p1_gnt,    v.expP1Gnt);
            checkBit ($sformatf("v%0d p0_stall", idx),  p0_stall,  v.expStall);
            checkBit ($sformatf("v%0d mem_read", idx),  mem_read,  v.expRead);
            checkBit ($sformatf("v%0d mem_write", idx), mem_write, v.expWrite);
            checkWord($sformatf("v%0d mem_addr", idx),  mem_addr,  v.expAddr);
            checkWord($sformatf("v%0d mem_wdata", idx), mem_wdata, v.expWdata);
        end else begin
            checkBit ($sformatf("v%0d p0_rvalid", idx), p0_rvalid, v.expRv0);
            checkBit ($sformatf("v%0d p1_rvalid", idx), p1_rvalid, v.expRv1);
            checkBit ($sformatf("v%0d addr_err", idx),  addr_err,  v.expErr);
            if (v.chkRdata) checkWord($sformatf("v%0d rdata", idx), rdata, v.expRdata);
        end
    endtask

    task automatic idleInputs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    endtask

    initial begin
        //           p0 req,we,addr,wdata          p1 req,we,addr,wdata           gnt0,gnt1,stall,rd,wr,addr,wdata                rv0,rv1,err,chk,rdata
        vecs[0]  = '{1'b1,1'b1,32'h200,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b1,32'h200,32'hDEADBEEF,  1'b0,1'b0,1'b0,1'b1,32'hA5000080};
        vecs[1]  = '{1'b1,1'b0,32'h200,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,1'b0,1'b1,1'b0,32'h200,32'h0,         1'b1,1'b0,1'b0,1'b1,32'hDEADBEEF};
        vecs[2]  = '{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,32'h0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,32'h0,32'h0,           1'b0,1'b1,1'b0,1'b1,32'hA5000000};
        vecs[3]  = '{1'b1,1'b0,32'h800,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,32'h800,32'h0,         1'b1,1'b0,1'b1,1'b1,32'h0};
        vecs[4]  = '{1'b1,1'b1,32'h2,32'h11111111,   1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,32'h2,32'h11111111,    1'b0,1'b0,1'b1,1'b1,32'h0};
        vecs[5]  = '{1'b1,1'b0,32'h4,32'h0,          1'b1,1'b1,32'h8,32'h12345678, 1'b1,1'b0,1'b0,1'b1,1'b0,32'h4,32'h0,           1'b1,1'b0,1'b0,1'b1,32'hA5000001};
        vecs[6]  = '{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b1,32'h8,32'h12345678, 1'b0,1'b1,1'b0,1'b0,1'b1,32'h8,32'h12345678,    1'b0,1'b0,1'b0,1'b1,32'hA5000001};
        vecs[7]  = '{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,32'h8,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,32'h8,32'h0,           1'b0,1'b1,1'b0,1'b1,32'h12345678};
        vecs[8]  = '{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,32'h7FC,32'h0,      1'b0,1'b1,1'b0,1'b1,1'b0,32'h7FC,32'h0,         1'b0,1'b1,1'b0,1'b1,32'hA50001FF};
        vecs[9]  = '{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,32'h1000,32'h0,     1'b0,1'b1,1'b0,1'b0,1'b0,32'h1000,32'h0,        1'b0,1'b1,1'b1,1'b1,32'h0};
        vecs[10] = '{1'b0,1'b0,32'h44,32'h55,        1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h44,32'h55,         1'b0,1'b0,1'b0,1'b1,32'h0};
        vecs[11] = '{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b1,32'h1,32'h77,       1'b0,1'b1,1'b0,1'b0,1'b0,32'h1,32'h77,          1'b0,1'b0,1'b1,1'b1,32'h0};
        vecs[12] = '{1'b1,1'b1,32'h7FC,32'hCAFEF00D, 1'b1,1'b0,32'h0,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b1,32'h7FC,32'hCAFEF00D,  1'b0,1'b0,1'b0,1'b1,32'h0};
        vecs[13] = '{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,32'h7FC,32'h0,      1'b0,1'b1,1'b0,1'b1,1'b0,32'h7FC,32'h0,         1'b0,1'b1,1'b0,1'b1,32'hCAFEF00D};

        // Reset held with a CPU read pending: nothing issued, nothing valid.
        reset_n = 1'b0;
        idleInputs();
        p0_req  = 1'b1;
        p0_addr = 32'h200;
        #12;
        checkBit ("rst mem_read",  mem_read,  1'b0);
        checkBit ("rst mem_write", mem_write, 1'b0);
        checkBit ("rst p0_rvalid", p0_rvalid, 1'b0);
        checkBit ("rst p1_rvalid", p1_rvalid, 1'b0);
        checkBit ("rst addr_err",  addr_err,  1'b0);
        checkWord("rst rdata",     rdata,     32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkBit("release p0_gnt",   p0_gnt,   1'b1);
        checkBit("release mem_read", mem_read, 1'b1);
        @(posedge clk); #1;
        checkBit ("release p0_rvalid", p0_rvalid, 1'b1);
        checkWord("release rdata",     rdata,     32'hA5000080);

        // Table of single-cycle accesses.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(i, vecs[i], 1'b0);
            @(posedge clk); #1;
            checkOutput(i, vecs[i], 1'b1);
        end

        // Both ports hold requests: CPU wins four cycles, DMA is forced on the fifth.
        @(negedge clk);
        idleInputs();
        p0_req = 1'b1; p0_addr = 32'h10;
        p1_req = 1'b1; p1_addr = 32'h20;
        for (int c = 1; c <= 10; c++) begin
            #1;
            checkBit($sformatf("starve c%0d p0_gnt", c),   p0_gnt,   (c % 5) != 0);
            checkBit($sformatf("starve c%0d p1_gnt", c),   p1_gnt,   (c % 5) == 0);
            checkBit($sformatf("starve c%0d p0_stall", c), p0_stall, (c % 5) == 0);
            @(posedge clk); #1;
            checkBit ($sformatf("starve c%0d p0_rvalid", c), p0_rvalid, (c % 5) != 0);
            checkBit ($sformatf("starve c%0d p1_rvalid", c), p1_rvalid, (c % 5) == 0);
            checkWord($sformatf("starve c%0d rdata", c), rdata, ((c % 5) == 0) ? 32'hA5000008 : 32'hA5000004);
            @(negedge clk);
        end

        // Reset in the cycle after a DMA read grant drops the pending valid.
        idleInputs();
        p1_req = 1'b1;
        #1;
        checkBit("flight p1_gnt", p1_gnt, 1'b1);
        @(posedge clk); #1;
        checkBit("flight p1_rvalid", p1_rvalid, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        checkBit ("flight rst p1_rvalid", p1_rvalid, 1'b0);
        checkWord("flight rst rdata",     rdata,     32'h0);
        checkBit ("flight rst mem_read",  mem_read,  1'b0);
        @(negedge clk);
        p1_req  = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkBit("post rst p0_rvalid", p0_rvalid, 1'b0);
        checkBit("post rst p1_rvalid", p1_rvalid, 1'b0);
        checkBit("post rst addr_err",  addr_err,  1'b0);

        // Reset clears a partly-run starvation count: after release the DMA
        // port again waits four full cycles.
        @(negedge clk);
        p0_req = 1'b1; p0_addr = 32'h10;
        p1_req = 1'b1; p1_addr = 32'h20;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkBit("ctr rst mem_read", mem_read, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checkBit($sformatf("ctr rst c%0d p0_gnt", c), p0_gnt, c != 5);
            checkBit($sformatf("ctr rst c%0d p1_gnt", c), p1_gnt, c == 5);
            @(negedge clk);
        end
        idleInputs();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
